// File: rtl/piradip_sysref_capture.sv
// SYSREF capture: synchronises SYSREF, measures and locks onto its period, and
// on request forwards exactly N whole SYSREF pulses before closing the gate.
module piradip_sysref_capture #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int LOCK_COUNT  = 4,
  parameter int TOL         = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             sysref_in,
  input  logic             arm,
  input  logic [7:0]       pass_count,
  input  logic             clr_err,
  output logic             sysref_out,
  output logic             stable,
  output logic [CNT_W-1:0] period,
  output logic             period_err,
  output logic             busy,
  output logic             done
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] TOL_VAL  = CNT_W'(TOL);
  localparam logic [MW-1:0]    LOCK_VAL = MW'(LOCK_COUNT);

  typedef enum logic [1:0] {
    DISARMED,
    ARMED,
    PASSING,
    DONE
  } gateState_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sDly_q;
  logic                   sNow;
  logic                   rise;
  logic                   fall;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] diff;
  logic [MW-1:0]    matchCnt_q, matchCnt_d;
  logic             valid_q, valid_d;
  logic             stable_q, stable_d;
  logic             err_q, err_d;
  logic             match;
  logic             mismatch;
  logic             timeout;

  gateState_e state_q, state_d;
  logic [7:0] passN_q, passN_d;
  logic [7:0] pulseK_q, pulseK_d;
  logic       out_q, out_d;

  assign sNow = sync_q[SYNC_STAGES-1];
  assign rise = sNow & ~sDly_q;
  assign fall = ~sNow & sDly_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q     <= '0;
      sDly_q     <= 1'b0;
      cnt_q      <= '0;
      period_q   <= '0;
      matchCnt_q <= '0;
      valid_q    <= 1'b0;
      stable_q   <= 1'b0;
      err_q      <= 1'b0;
      state_q    <= DISARMED;
      passN_q    <= '0;
      pulseK_q   <= '0;
      out_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], sysref_in};
      sDly_q     <= sNow;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      matchCnt_q <= matchCnt_d;
      valid_q    <= valid_d;
      stable_q   <= stable_d;
      err_q      <= err_d;
      state_q    <= state_d;
      passN_q    <= passN_d;
      pulseK_q   <= pulseK_d;
      out_q      <= out_d;
    end
  end

  // The first rise after reset or timeout only starts a measurement window.
  always_comb begin
    cnt_d      = cnt_q;
    period_d   = period_q;
    matchCnt_d = matchCnt_q;
    valid_d    = valid_q;
    mismatch   = 1'b0;
    diff       = (cnt_q >= period_q) ? (cnt_q - period_q) : (period_q - cnt_q);
    match      = (diff <= TOL_VAL);
    timeout    = !rise && (cnt_q == (CNT_MAX - CNT_W'(1)));

    if (rise) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (rise) begin
      if (valid_q) begin
        if (match) begin
          if (matchCnt_q != LOCK_VAL) begin
            matchCnt_d = matchCnt_q + MW'(1);
          end
        end else begin
          mismatch   = 1'b1;
          matchCnt_d = '0;
          period_d   = cnt_q;
        end
      end else begin
        valid_d = 1'b1;
      end
    end else if (timeout) begin
      matchCnt_d = '0;
      valid_d    = 1'b0;
    end

    stable_d = (matchCnt_d == LOCK_VAL);

    err_d = err_q;
    if (stable_q && (mismatch || timeout)) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end
  end

  // A lock loss on the passing edge aborts immediately so no partial pulse escapes.
  always_comb begin
    state_d  = state_q;
    passN_d  = passN_q;
    pulseK_d = pulseK_q;
    out_d    = 1'b0;

    case (state_q)
      DISARMED, DONE: begin
        if (arm) begin
          state_d  = ARMED;
          passN_d  = (pass_count == 8'd0) ? 8'd1 : pass_count;
          pulseK_d = '0;
        end
      end
      ARMED: begin
        if (rise && stable_q) begin
          if (stable_d) begin
            state_d  = PASSING;
            pulseK_d = 8'd1;
            out_d    = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      PASSING: begin
        if (!stable_d) begin
          state_d = DONE;
        end else if (fall && (pulseK_q == passN_q)) begin
          state_d = DONE;
        end else begin
          out_d = sNow;
          if (rise) begin
            pulseK_d = pulseK_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = DISARMED;
      end
    endcase
  end

  assign sysref_out = out_q;
  assign stable     = stable_q;
  assign period     = period_q;
  assign period_err = err_q;
  assign busy       = (state_q == ARMED) || (state_q == PASSING);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_piradip_sysref_capture.sv
// Self-checking bench for piradip_sysref_capture: a pulse-level reference model
// tracks lock, period and error state from the SYSREF rise times it generates.
module tb_piradip_sysref_capture;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = 255;

  logic             clk = 1'b0;
  logic             resetn;
  logic             sysref_in;
  logic             arm;
  logic [7:0]       pass_count;
  logic             clr_err;
  logic             sysref_out;
  logic             stable;
  logic [CNT_W-1:0] period;
  logic             period_err;
  logic             busy;
  logic             done;

  piradip_sysref_capture #(
    .SYNC_STAGES(2),
    .CNT_W      (CNT_W),
    .LOCK_COUNT (4),
    .TOL        (1)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .sysref_in (sysref_in),
    .arm       (arm),
    .pass_count(pass_count),
    .clr_err   (clr_err),
    .sysref_out(sysref_out),
    .stable    (stable),
    .period    (period),
    .period_err(period_err),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  // Reference model state, updated once per generated SYSREF rise.
  bit mValid, mStable, mErr, mTimedOut;
  int mPeriod, mMatch, lastRise;

  // Completed high-phase widths seen on sysref_out.
  int outWidths[$];
  int curW = 0;

  always @(negedge clk) begin
    if (!resetn) begin
      curW = 0;
    end else if (sysref_out === 1'b1) begin
      curW++;
    end else if (curW > 0) begin
      outWidths.push_back(curW);
      curW = 0;
    end
  end

  task automatic modelReset();
    mValid    = 1'b0;
    mStable   = 1'b0;
    mErr      = 1'b0;
    mTimedOut = 1'b0;
    mPeriod   = 0;
    mMatch    = 0;
    lastRise  = cyc;
  endtask

  task automatic modelAdvance();
    if (!mTimedOut && (cyc - lastRise >= CNT_MAX)) begin
      if (mStable) mErr = 1'b1;
      mMatch    = 0;
      mStable   = 1'b0;
      mValid    = 1'b0;
      mTimedOut = 1'b1;
    end
  endtask

  task automatic modelRise();
    int meas;
    int d;
    modelAdvance();
    if (mValid) begin
      meas = cyc - lastRise;
      d    = (meas > mPeriod) ? meas - mPeriod : mPeriod - meas;
      if (d <= 1) begin
        if (mMatch < 4) mMatch++;
      end else begin
        if (mStable) mErr = 1'b1;
        mMatch  = 0;
        mPeriod = meas;
      end
      mStable = (mMatch == 4);
    end else begin
      mValid = 1'b1;
    end
    lastRise  = cyc;
    mTimedOut = 1'b0;
  endtask

  // One SYSREF pulse: p cycles rise-to-rise, h cycles high; optional arm/clear at the fall.
  task automatic genPulse(input int p, input int h, input bit doArm, input logic [7:0] pc,
                          input bit doClr);
    @(negedge clk);
    sysref_in = 1'b1;
    modelRise();
    repeat (h) @(negedge clk);
    sysref_in = 1'b0;
    if (doArm) begin
      arm        = 1'b1;
      pass_count = pc;
    end
    if (doClr) begin
      clr_err = 1'b1;
      mErr    = 1'b0;
    end
    @(negedge clk);
    arm     = 1'b0;
    clr_err = 1'b0;
    repeat (p - h - 2) @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    resetn    = 1'b0;
    sysref_in = 1'b0;
    arm       = 1'b0;
    clr_err   = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    modelReset();
    outWidths.delete();
  endtask

  task automatic test_reset();
    logic [7:0] expP;
    @(negedge clk);
    resetn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sysref_in = 1'($urandom_range(0, 1));
      arm       = 1'($urandom_range(0, 1));
      clr_err   = 1'($urandom_range(0, 1));
      total++;
      if ({sysref_out, stable, period, period_err, busy, done} !== '0) begin
        bad++;
        $display("[TB] FAIL reset_outputs: got=%b expected all zero",
                 {sysref_out, stable, period, period_err, busy, done});
      end
    end
    sysref_in = 1'b0;
    arm       = 1'b0;
    clr_err   = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    modelReset();
    outWidths.delete();
    for (int i = 0; i < 6; i++) begin
      genPulse(20, 10, 1'b0, 8'd0, 1'b0);
      total++;
      if (stable !== mStable) begin
        bad++;
        $display("[TB] FAIL lock_stable[%0d]: got=%b expected=%b", i, stable, mStable);
      end
    end
    total++;
    if (stable !== 1'b1) begin
      bad++;
      $display("[TB] FAIL lock_final_stable: got=%b expected=1", stable);
    end
    expP = 8'd20;
    total++;
    if (period !== expP) begin
      bad++;
      $display("[TB] FAIL lock_period: got=%0d expected=%0d", period, expP);
    end
    total++;
    if (period_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL lock_err: got=%b expected=0", period_err);
    end
  endtask

  task automatic test_gated_pass();
    int n, h, p, extra;
    for (int it = 0; it < 3; it++) begin
      if (it == 0) begin
        n = 3;
        h = 10;
      end else begin
        n = int'($urandom_range(1, 4));
        h = int'($urandom_range(3, 12));
      end
      extra = int'($urandom_range(1, 3));
      outWidths.delete();
      genPulse(20, h, 1'b1, 8'(n), 1'b0);
      total++;
      if ({busy, done} !== 2'b10) begin
        bad++;
        $display("[TB] FAIL pass_armed[%0d]: busy/done got=%b expected=10", it, {busy, done});
      end
      for (int k = 0; k < n + extra; k++) begin
        p = (it == 0) ? 20 : 20 + int'($urandom_range(0, 1));
        genPulse(p, h, 1'b0, 8'd0, 1'b0);
        if (k == n - 1) begin
          total++;
          if ({busy, done} !== 2'b01) begin
            bad++;
            $display("[TB] FAIL pass_done_at_n[%0d]: busy/done got=%b expected=01", it, {busy, done});
          end
        end else if (k < n - 1) begin
          total++;
          if (busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL pass_busy[%0d]: got=%b expected=1", it, busy);
          end
        end
      end
      total++;
      if (outWidths.size() != n) begin
        bad++;
        $display("[TB] FAIL pass_count[%0d]: got=%0d pulses expected=%0d", it, outWidths.size(), n);
      end
      foreach (outWidths[j]) begin
        total++;
        if (outWidths[j] != h) begin
          bad++;
          $display("[TB] FAIL pass_width[%0d][%0d]: got=%0d expected=%0d", it, j, outWidths[j], h);
        end
      end
      total++;
      if ({sysref_out, stable, period_err} !== {1'b0, mStable, mErr}) begin
        bad++;
        $display("[TB] FAIL pass_after[%0d]: out/stable/err got=%b expected=%b", it,
                 {sysref_out, stable, period_err}, {1'b0, mStable, mErr});
      end
    end
  endtask

  task automatic test_arm_before_lock();
    doReset();
    @(negedge clk);
    arm        = 1'b1;
    pass_count = 8'd0;
    @(negedge clk);
    arm = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL early_arm_busy: got=%b expected=1", busy);
    end
    for (int i = 0; i < 6; i++) genPulse(20, 10, 1'b0, 8'd0, 1'b0);
    total++;
    if (stable !== mStable || outWidths.size() != 0 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL early_hold: stable=%b pulses=%0d busy=%b expected stable=%b pulses=0 busy=1",
               stable, outWidths.size(), busy, mStable);
    end
    for (int i = 0; i < 3; i++) genPulse(20, 10, 1'b0, 8'd0, 1'b0);
    total++;
    if (outWidths.size() != 1) begin
      bad++;
      $display("[TB] FAIL early_count: got=%0d pulses expected=1", outWidths.size());
    end else begin
      total++;
      if (outWidths[0] != 10) begin
        bad++;
        $display("[TB] FAIL early_width: got=%0d expected=10", outWidths[0]);
      end
    end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("[TB] FAIL early_done: got=%b expected=1", done);
    end
  endtask

  task automatic test_jitter();
    logic [7:0] expP;
    for (int i = 0; i < 8; i++) begin
      genPulse((i % 2 == 1) ? 21 : 20, int'($urandom_range(3, 10)), 1'b0, 8'd0, 1'b0);
      expP = mPeriod[7:0];
      total++;
      if ({stable, period_err, period} !== {mStable, mErr, expP} || stable !== 1'b1) begin
        bad++;
        $display("[TB] FAIL jitter[%0d]: stable/err/period got=%b/%b/%0d expected=%b/%b/%0d",
                 i, stable, period_err, period, mStable, mErr, expP);
      end
    end
    genPulse(25, 10, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      genPulse(25, 10, 1'b0, 8'd0, 1'b0);
      expP = mPeriod[7:0];
      total++;
      if ({stable, period_err, period} !== {mStable, mErr, expP}) begin
        bad++;
        $display("[TB] FAIL relock[%0d]: stable/err/period got=%b/%b/%0d expected=%b/%b/%0d",
                 i, stable, period_err, period, mStable, mErr, expP);
      end
      if (i == 0) begin
        total++;
        if ({stable, period_err} !== 2'b01 || period !== 8'd25) begin
          bad++;
          $display("[TB] FAIL outlier: stable/err/period got=%b/%b/%0d expected=0/1/25",
                   stable, period_err, period);
        end
      end
    end
    total++;
    if (stable !== 1'b1) begin
      bad++;
      $display("[TB] FAIL relock_final: got=%b expected=1", stable);
    end
    genPulse(25, 10, 1'b0, 8'd0, 1'b1);
    total++;
    if (period_err !== mErr || period_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL clr_err: got=%b expected=0", period_err);
    end
  endtask

  task automatic test_loss_mid_pass();
    outWidths.delete();
    genPulse(25, 10, 1'b1, 8'd5, 1'b0);
    for (int i = 0; i < 2; i++) genPulse(25, 10, 1'b0, 8'd0, 1'b0);
    total++;
    if (busy !== 1'b1 || outWidths.size() != 2) begin
      bad++;
      $display("[TB] FAIL loss_passing: busy=%b pulses=%0d expected busy=1 pulses=2", busy, outWidths.size());
    end
    repeat (300) @(negedge clk);
    modelAdvance();
    total++;
    if ({done, busy, sysref_out, stable, period_err} !== {1'b1, 1'b0, 1'b0, mStable, mErr}) begin
      bad++;
      $display("[TB] FAIL loss_timeout: done/busy/out/stable/err got=%b expected=%b",
               {done, busy, sysref_out, stable, period_err}, {1'b1, 1'b0, 1'b0, mStable, mErr});
    end
    total++;
    if (period_err !== 1'b1 || outWidths.size() != 2) begin
      bad++;
      $display("[TB] FAIL loss_err: err=%b pulses=%0d expected err=1 pulses=2", period_err, outWidths.size());
    end
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    mErr    = 1'b0;
    total++;
    if (period_err !== mErr) begin
      bad++;
      $display("[TB] FAIL loss_clr: got=%b expected=%b", period_err, mErr);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) genPulse(20, 10, 1'b0, 8'd0, 1'b0);
    total++;
    if (stable !== mStable || stable !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ar_prelock: got=%b expected=1", stable);
    end
    genPulse(20, 10, 1'b1, 8'd5, 1'b0);
    genPulse(20, 10, 1'b0, 8'd0, 1'b0);
    @(negedge clk);
    sysref_in = 1'b1;
    modelRise();
    repeat (5) @(negedge clk);
    total++;
    if ({sysref_out, busy} !== 2'b11) begin
      bad++;
      $display("[TB] FAIL ar_midpulse: out/busy got=%b expected=11", {sysref_out, busy});
    end
    @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    total++;
    if ({sysref_out, busy, done, stable} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL ar_immediate: out/busy/done/stable got=%b expected=0000",
               {sysref_out, busy, done, stable});
    end
    sysref_in = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    modelReset();
    outWidths.delete();
    for (int i = 0; i < 6; i++) genPulse(20, 10, 1'b0, 8'd0, 1'b0);
    total++;
    if ({stable, period_err, period} !== {mStable, mErr, 8'd20} || stable !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ar_relock: stable/err/period got=%b/%b/%0d expected=1/0/20",
               stable, period_err, period);
    end
    total++;
    if ({sysref_out, busy, done} !== 3'b000 || outWidths.size() != 0) begin
      bad++;
      $display("[TB] FAIL ar_idle: out/busy/done got=%b pulses=%0d expected 000 and 0",
               {sysref_out, busy, done}, outWidths.size());
    end
  endtask

  initial begin
    resetn     = 1'b0;
    sysref_in  = 1'b0;
    arm        = 1'b0;
    pass_count = 8'd0;
    clr_err    = 1'b0;
    modelReset();
    test_reset();
    test_gated_pass();
    test_arm_before_lock();
    test_jitter();
    test_loss_mid_pass();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
